// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the divide unit
package alu_pkg;

  localparam int WIDTH_DEF = 4;

  // Quotient reported on divide-by-zero; sliced down to the instance width.
  localparam logic [31:0] DIVZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_4b_if.sv
// rtl/seq_div_4b_if.sv - start/busy/done handshake and operand/result bundle
interface seq_div_4b_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, zero
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] carry;

  assign shifted  = {rem, q_msb};
  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  // Invert-and-add-one subtraction; carry out of the top cell means no borrow.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (shifted[i]),
      .b    (sub_b[i]),
      .cin  (carry[i]),
      .sum  (trial[i]),
      .cout (carry[i+1])
    );
  end

  assign q_bit    = carry[WIDTH+1] & ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_div_4b.sv
// rtl/seq_div_4b.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
module seq_div_4b
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_div_4b_if.slave  d
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             accept;
  logic             busy_c;
  logic             done_c;

  // A new request may be taken in IDLE or in the single DONE cycle.
  assign accept = d.start && (state == IDLE || state == DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q_msb    (q_reg[WIDTH-1]),
    .divisor  (div_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (d.divisor == '0) ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (count == '0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CALC:    busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      q_reg       <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else if (accept) begin
      q_reg   <= d.dividend;
      div_reg <= d.divisor;
      rem_reg <= '0;
      count   <= CNT_W'(WIDTH - 1);
      // Divide-by-zero skips the iterations and publishes results immediately.
      if (d.divisor == '0) begin
        quotient_q  <= DIVZ_QUOTIENT[WIDTH-1:0];
        remainder_q <= d.dividend;
        div_zero_q  <= 1'b1;
      end
    end else if (state == CALC) begin
      q_reg   <= {q_reg[WIDTH-2:0], q_bit};
      rem_reg <= rem_next;
      if (count == '0) begin
        quotient_q  <= {q_reg[WIDTH-2:0], q_bit};
        remainder_q <= rem_next;
        div_zero_q  <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign d.busy      = busy_c;
  assign d.done      = done_c;
  assign d.quotient  = quotient_q;
  assign d.remainder = remainder_q;
  assign d.div_zero  = div_zero_q;
  assign d.zero      = (quotient_q == '0);

endmodule

// File: tb/tb_seq_div_4b.sv
// tb/tb_seq_div_4b.sv - self-checking bench for seq_div_4b against an arithmetic reference
module tb_seq_div_4b;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;

  seq_div_4b_if #(.WIDTH(W)) dif ();

  seq_div_4b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dif.done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!dif.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int exp_q;
    int exp_r;
    exp_q = (b == 0) ? (1 << W) - 1 : a / b;
    exp_r = (b == 0) ? a : a % b;
    check({tag, ".done"}, 32'(dif.done), 32'd1);
    check({tag, ".quotient"}, 32'(dif.quotient), 32'(exp_q));
    check({tag, ".remainder"}, 32'(dif.remainder), 32'(exp_r));
    check({tag, ".div_zero"}, 32'(dif.div_zero), 32'(b == 0));
    check({tag, ".zero"}, 32'(dif.zero), 32'(exp_q == 0));
    if (b != 0) begin
      check({tag, ".invariant"},
            32'((int'(dif.quotient) * b + int'(dif.remainder) == a) && (int'(dif.remainder) < b)),
            32'd1);
    end
  endtask

  task automatic do_div(input int a, input int b, input string tag);
    int lat;
    @(negedge clk);
    dif.dividend = 4'(a);
    dif.divisor  = 4'(b);
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    dif.dividend = 4'($urandom);
    dif.divisor  = 4'($urandom);
    check({tag, ".busy"}, 32'(dif.busy), 32'(b != 0));
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), 32'((b == 0) ? 0 : W));
    check_result(tag, a, b);
  endtask

  initial begin
    int lat;
    int n0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(dif.busy), 32'd0);
    check("reset.done", 32'(dif.done), 32'd0);
    check("reset.quotient", 32'(dif.quotient), 32'd0);
    check("reset.remainder", 32'(dif.remainder), 32'd0);
    check("reset.div_zero", 32'(dif.div_zero), 32'd0);
    check("reset.zero", 32'(dif.zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(13, 3, "d13_3");
    do_div(3, 9, "d3_9");
    do_div(15, 1, "d15_1");
    do_div(7, 0, "d7_0");

    // Start pulsed mid-calculation must be ignored.
    n0 = n_done;
    @(negedge clk);
    dif.dividend = 4'd13;
    dif.divisor  = 4'd3;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    @(negedge clk);
    dif.dividend = 4'd8;
    dif.divisor  = 4'd2;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done(lat);
    check("ign.latency", 32'(lat), 32'(W - 1));
    check_result("ign", 13, 3);
    repeat (8) @(posedge clk);
    #2;
    check("ign.done_count", 32'(n_done - n0), 32'd1);

    // Back-to-back: start held through the DONE cycle.
    @(negedge clk);
    dif.dividend = 4'd14;
    dif.divisor  = 4'd4;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.dividend = 4'd9;
    dif.divisor  = 4'd2;
    wait_done(lat);
    check("b2b1.latency", 32'(lat), 32'(W));
    check_result("b2b1", 14, 4);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("b2b2.busy", 32'(dif.busy), 32'd1);
    wait_done(lat);
    check("b2b2.latency", 32'(lat), 32'(W));
    check_result("b2b2", 9, 2);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    dif.dividend = 4'd15;
    dif.divisor  = 4'd2;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    @(posedge clk);
    #1;
    n0 = n_done;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.busy", 32'(dif.busy), 32'd0);
    check("rst.done", 32'(dif.done), 32'd0);
    check("rst.quotient", 32'(dif.quotient), 32'd0);
    check("rst.remainder", 32'(dif.remainder), 32'd0);
    check("rst.zero", 32'(dif.zero), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("rst.no_done", 32'(n_done - n0), 32'd0);
    do_div(15, 2, "rst_after");

    for (int i = 0; i < 1000; i++) begin
      do_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
